// File: rtl/uart_fifo_mmio.sv
// Memory-mapped UART with TX/RX FIFOs, programmable baud divisor, optional parity
// and a boot-loader path that packs received bytes into instruction-memory words.

module uart_fifo_mmio_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned W     = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] head_c,
    output logic         empty_c,
    output logic         full_c
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          push_ok, pop_ok;

    assign empty_c = (cnt_q == '0);
    assign full_c  = (cnt_q == (AW+1)'(DEPTH));
    assign head_c  = mem_q[rd_q];

    // A push into a full FIFO succeeds only when a pop frees the slot in the same cycle
    always_comb begin
        pop_ok  = pop & ~empty_c;
        push_ok = push & (~full_c | pop_ok);
        mem_d   = mem_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        cnt_d   = cnt_q;
        if (push_ok) begin
            mem_d[wr_q] = din;
            wr_d        = wr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_d = rd_q + AW'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   cnt_d = cnt_q + (AW+1)'(1);
            2'b01:   cnt_d = cnt_q - (AW+1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

module uart_fifo_mmio #(
    parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
    parameter int unsigned DEF_DIV    = 5208,
    parameter int unsigned DIV_W      = 16,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        RX,
    output logic        TX,
    input  logic [31:0] A,
    input  logic [31:0] WD,
    input  logic        WE,
    input  logic        RE,
    output logic [31:0] RD,
    output logic        irq,
    output logic        imem_WE,
    output logic [31:0] imem_A,
    output logic [31:0] imem_WD,
    output logic        cpu_stall,
    output logic        prog_mode
);
    localparam logic [31:0] ADDR_DATA   = BASE_ADDR + 32'd4;
    localparam logic [31:0] ADDR_CTRL   = BASE_ADDR + 32'd8;
    localparam logic [31:0] ADDR_STATUS = BASE_ADDR + 32'd12;
    localparam logic [31:0] ADDR_BAUD   = BASE_ADDR + 32'd16;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_PAR   = 3'd3;
    localparam logic [2:0] S_STOP  = 3'd4;

    // Registers and flags
    logic [6:0]       ctrl_q, ctrl_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             ovf_q, ovf_d, ferr_q, ferr_d, perr_q, perr_d;
    logic [31:0]      rd_q, rd_d;
    logic             irq_q, irq_d;

    // TX path
    logic [2:0]       tx_state_q, tx_state_d;
    logic [DIV_W-1:0] tx_cnt_q, tx_cnt_d;
    logic [7:0]       tx_sh_q, tx_sh_d;
    logic [2:0]       tx_bit_q, tx_bit_d;
    logic             tx_stp_q, tx_stp_d, tx_par_q, tx_par_d, tx_q, tx_d;
    logic             tx_load, tx_push, tx_pop;
    logic [7:0]       tx_head;
    logic             tx_fifo_empty, tx_full, tx_empty_c;

    // RX path
    logic             rx_m_q, rx_s_q, rx_p_q;
    logic [2:0]       rx_state_q, rx_state_d;
    logic [DIV_W-1:0] rx_cnt_q, rx_cnt_d, rx_half;
    logic [7:0]       rx_sh_q, rx_sh_d;
    logic [2:0]       rx_bit_q, rx_bit_d;
    logic             rx_pbad_q, rx_pbad_d;
    logic             rx_good, rx_push, rx_pop, rx_byte_prog;
    logic             set_ferr, set_perr, set_ovf;
    logic [7:0]       rx_head;
    logic             rx_empty, rx_full;

    // Boot-loader word packer
    logic [1:0]       pk_cnt_q, pk_cnt_d;
    logic [23:0]      pk_word_q, pk_word_d;
    logic [31:0]      pk_addr_q, pk_addr_d;
    logic             imem_we_q, imem_we_d;
    logic [31:0]      imem_a_q, imem_a_d, imem_wd_q, imem_wd_d;

    logic             ctrl_wr, unused_wd;

    assign unused_wd = ^WD;

    uart_fifo_mmio_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_tx_fifo (
        .clk(CLK), .rst(reset), .push(tx_push), .pop(tx_pop), .din(WD[7:0]),
        .head_c(tx_head), .empty_c(tx_fifo_empty), .full_c(tx_full)
    );

    uart_fifo_mmio_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_rx_fifo (
        .clk(CLK), .rst(reset), .push(rx_push), .pop(rx_pop), .din(rx_sh_q),
        .head_c(rx_head), .empty_c(rx_empty), .full_c(rx_full)
    );

    assign tx_empty_c = tx_fifo_empty & (tx_state_q == S_IDLE);
    assign ctrl_wr    = WE && (A == ADDR_CTRL);

    // Bus decode, register file, read mux and sticky error flags
    always_comb begin
        logic clr;
        ctrl_d  = ctrl_q;
        div_d   = div_q;
        rd_d    = '0;
        tx_push = WE && (A == ADDR_DATA);
        rx_pop  = RE && (A == ADDR_DATA) && !rx_empty;
        clr     = RE && (A == ADDR_STATUS);
        if (ctrl_wr) begin
            ctrl_d = {WD[6:1], 1'b0};
        end
        if (WE && (A == ADDR_BAUD)) begin
            div_d = (WD[DIV_W-1:0] == '0) ? DIV_W'(1) : WD[DIV_W-1:0];
        end
        if (RE) begin
            case (A)
                ADDR_DATA:   rd_d = rx_empty ? 32'd0 : {24'd0, rx_head};
                ADDR_CTRL:   rd_d = {25'd0, ctrl_q};
                ADDR_STATUS: rd_d = {26'd0, ovf_q, ferr_q, perr_q, tx_full, tx_empty_c, ~rx_empty};
                ADDR_BAUD:   rd_d = 32'(div_q);
                default:     rd_d = '0;
            endcase
        end
        ovf_d  = (ovf_q  & ~clr) | set_ovf;
        ferr_d = (ferr_q & ~clr) | set_ferr;
        perr_d = (perr_q & ~clr) | set_perr;
        irq_d  = (~rx_empty & ctrl_q[5]) | (tx_empty_c & ctrl_q[6]);
    end

    // TX FSM; the bit counter reloads from div_q at every bit boundary
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_sh_d    = tx_sh_q;
        tx_bit_d   = tx_bit_q;
        tx_stp_d   = tx_stp_q;
        tx_par_d   = tx_par_q;
        tx_d       = tx_q;
        tx_pop     = 1'b0;
        tx_load    = 1'b0;
        if (tx_state_q != S_IDLE && tx_cnt_q != '0) begin
            tx_cnt_d = tx_cnt_q - DIV_W'(1);
        end
        case (tx_state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (!tx_fifo_empty) tx_load = 1'b1;
            end
            S_START: begin
                if (tx_cnt_q == '0) begin
                    tx_state_d = S_DATA;
                    tx_cnt_d   = div_q - DIV_W'(1);
                    tx_bit_d   = 3'd0;
                    tx_d       = tx_sh_q[0];
                end
            end
            S_DATA: begin
                if (tx_cnt_q == '0) begin
                    tx_cnt_d = div_q - DIV_W'(1);
                    if (tx_bit_q == 3'd7) begin
                        if (ctrl_q[2]) begin
                            tx_state_d = S_PAR;
                            tx_d       = tx_par_q;
                        end else begin
                            tx_state_d = S_STOP;
                            tx_stp_d   = 1'b0;
                            tx_d       = 1'b1;
                        end
                    end else begin
                        tx_bit_d = tx_bit_q + 3'd1;
                        tx_sh_d  = {1'b0, tx_sh_q[7:1]};
                        tx_d     = tx_sh_q[1];
                    end
                end
            end
            S_PAR: begin
                if (tx_cnt_q == '0) begin
                    tx_state_d = S_STOP;
                    tx_cnt_d   = div_q - DIV_W'(1);
                    tx_stp_d   = 1'b0;
                    tx_d       = 1'b1;
                end
            end
            S_STOP: begin
                if (tx_cnt_q == '0) begin
                    if (ctrl_q[4] && !tx_stp_q) begin
                        tx_stp_d = 1'b1;
                        tx_cnt_d = div_q - DIV_W'(1);
                    end else if (!tx_fifo_empty) begin
                        tx_load = 1'b1;
                    end else begin
                        tx_state_d = S_IDLE;
                        tx_d       = 1'b1;
                    end
                end
            end
            default: begin
                tx_state_d = S_IDLE;
                tx_d       = 1'b1;
            end
        endcase
        if (tx_load) begin
            tx_pop     = 1'b1;
            tx_state_d = S_START;
            tx_cnt_d   = div_q - DIV_W'(1);
            tx_sh_d    = tx_head;
            tx_par_d   = ^tx_head ^ ctrl_q[3];
            tx_d       = 1'b0;
        end
    end

    // RX FSM; start is confirmed at half a bit, then every bit sampled mid-bit
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_sh_d    = rx_sh_q;
        rx_bit_d   = rx_bit_q;
        rx_pbad_d  = rx_pbad_q;
        rx_good    = 1'b0;
        set_ferr   = 1'b0;
        set_perr   = 1'b0;
        rx_half    = div_q >> 1;
        if (rx_state_q != S_IDLE && rx_cnt_q != '0) begin
            rx_cnt_d = rx_cnt_q - DIV_W'(1);
        end
        case (rx_state_q)
            S_IDLE: begin
                if (rx_p_q && !rx_s_q) begin
                    rx_state_d = S_START;
                    rx_cnt_d   = (rx_half == '0) ? '0 : rx_half - DIV_W'(1);
                    rx_pbad_d  = 1'b0;
                end
            end
            S_START: begin
                if (rx_cnt_q == '0) begin
                    rx_state_d = rx_s_q ? S_IDLE : S_DATA;
                    rx_cnt_d   = div_q - DIV_W'(1);
                    rx_bit_d   = 3'd0;
                end
            end
            S_DATA: begin
                if (rx_cnt_q == '0) begin
                    rx_sh_d  = {rx_s_q, rx_sh_q[7:1]};
                    rx_cnt_d = div_q - DIV_W'(1);
                    rx_bit_d = rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'd7) begin
                        rx_state_d = ctrl_q[2] ? S_PAR : S_STOP;
                    end
                end
            end
            S_PAR: begin
                if (rx_cnt_q == '0) begin
                    rx_pbad_d  = rx_s_q != (^rx_sh_q ^ ctrl_q[3]);
                    rx_state_d = S_STOP;
                    rx_cnt_d   = div_q - DIV_W'(1);
                end
            end
            S_STOP: begin
                if (rx_cnt_q == '0) begin
                    rx_state_d = S_IDLE;
                    if (!rx_s_q)        set_ferr = 1'b1;
                    else if (rx_pbad_q) set_perr = 1'b1;
                    else                rx_good  = 1'b1;
                end
            end
            default: rx_state_d = S_IDLE;
        endcase
        rx_push      = rx_good & ~ctrl_q[1];
        rx_byte_prog = rx_good & ctrl_q[1];
        set_ovf      = rx_push & rx_full & ~rx_pop;
    end

    // Little-endian word packer; any change of prog mode drops a partial word
    always_comb begin
        pk_cnt_d  = pk_cnt_q;
        pk_word_d = pk_word_q;
        pk_addr_d = pk_addr_q;
        imem_we_d = 1'b0;
        imem_a_d  = imem_a_q;
        imem_wd_d = imem_wd_q;
        if (rx_byte_prog) begin
            pk_cnt_d = pk_cnt_q + 2'd1;
            case (pk_cnt_q)
                2'd0: pk_word_d[7:0]   = rx_sh_q;
                2'd1: pk_word_d[15:8]  = rx_sh_q;
                2'd2: pk_word_d[23:16] = rx_sh_q;
                default: begin
                    imem_we_d = 1'b1;
                    imem_a_d  = pk_addr_q;
                    imem_wd_d = {rx_sh_q, pk_word_q};
                    pk_addr_d = pk_addr_q + 32'd4;
                end
            endcase
        end
        if (ctrl_wr && (WD[1] != ctrl_q[1])) begin
            pk_cnt_d  = 2'd0;
            pk_word_d = '0;
            if (WD[1]) pk_addr_d = '0;
        end
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            ctrl_q     <= '0;
            div_q      <= DIV_W'(DEF_DIV);
            ovf_q      <= 1'b0;
            ferr_q     <= 1'b0;
            perr_q     <= 1'b0;
            rd_q       <= '0;
            irq_q      <= 1'b0;
            tx_state_q <= S_IDLE;
            tx_cnt_q   <= '0;
            tx_sh_q    <= '0;
            tx_bit_q   <= '0;
            tx_stp_q   <= 1'b0;
            tx_par_q   <= 1'b0;
            tx_q       <= 1'b1;
            rx_m_q     <= 1'b1;
            rx_s_q     <= 1'b1;
            rx_p_q     <= 1'b1;
            rx_state_q <= S_IDLE;
            rx_cnt_q   <= '0;
            rx_sh_q    <= '0;
            rx_bit_q   <= '0;
            rx_pbad_q  <= 1'b0;
            pk_cnt_q   <= '0;
            pk_word_q  <= '0;
            pk_addr_q  <= '0;
            imem_we_q  <= 1'b0;
            imem_a_q   <= '0;
            imem_wd_q  <= '0;
        end else begin
            ctrl_q     <= ctrl_d;
            div_q      <= div_d;
            ovf_q      <= ovf_d;
            ferr_q     <= ferr_d;
            perr_q     <= perr_d;
            rd_q       <= rd_d;
            irq_q      <= irq_d;
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_sh_q    <= tx_sh_d;
            tx_bit_q   <= tx_bit_d;
            tx_stp_q   <= tx_stp_d;
            tx_par_q   <= tx_par_d;
            tx_q       <= tx_d;
            rx_m_q     <= RX;
            rx_s_q     <= rx_m_q;
            rx_p_q     <= rx_s_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_sh_q    <= rx_sh_d;
            rx_bit_q   <= rx_bit_d;
            rx_pbad_q  <= rx_pbad_d;
            pk_cnt_q   <= pk_cnt_d;
            pk_word_q  <= pk_word_d;
            pk_addr_q  <= pk_addr_d;
            imem_we_q  <= imem_we_d;
            imem_a_q   <= imem_a_d;
            imem_wd_q  <= imem_wd_d;
        end
    end

    assign TX        = tx_q;
    assign RD        = rd_q;
    assign irq       = irq_q;
    assign imem_WE   = imem_we_q;
    assign imem_A    = imem_a_q;
    assign imem_WD   = imem_wd_q;
    assign prog_mode = ctrl_q[1];
    assign cpu_stall = ctrl_q[1];
endmodule

// File: tb/tb_uart_fifo_mmio.sv
// Directed bench for uart_fifo_mmio: registers, TX framing, RX parity/overflow/errors, boot-loader packing.

module tb_uart_fifo_mmio;
    localparam logic [31:0] BASE     = 32'h8000_0000;
    localparam logic [31:0] A_DATA   = BASE + 32'd4;
    localparam logic [31:0] A_CTRL   = BASE + 32'd8;
    localparam logic [31:0] A_STATUS = BASE + 32'd12;
    localparam logic [31:0] A_BAUD   = BASE + 32'd16;
    localparam int BIT = 16;

    logic        CLK = 1'b0;
    logic        reset, RX, TX, WE, RE, irq, imem_WE, cpu_stall, prog_mode;
    logic [31:0] A, WD, RD, imem_A, imem_WD;

    int n_checks = 0;
    int n_fail   = 0;
    int we_cnt   = 0;
    logic [31:0] cap_a [4];
    logic [31:0] cap_wd [4];

    uart_fifo_mmio dut (
        .CLK(CLK), .reset(reset), .RX(RX), .TX(TX), .A(A), .WD(WD), .WE(WE), .RE(RE),
        .RD(RD), .irq(irq), .imem_WE(imem_WE), .imem_A(imem_A), .imem_WD(imem_WD),
        .cpu_stall(cpu_stall), .prog_mode(prog_mode)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (imem_WE === 1'b1) begin
            if (we_cnt < 4) begin
                cap_a[we_cnt]  = imem_A;
                cap_wd[we_cnt] = imem_WD;
            end
            we_cnt++;
        end
    end

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        @(negedge CLK);
        A = a; WD = d; WE = 1'b1;
        @(negedge CLK);
        WE = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        @(negedge CLK);
        A = a; RE = 1'b1;
        @(negedge CLK);
        RE = 1'b0;
        d = RD;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit use_par, input logic pbit, input logic stopb);
        @(negedge CLK);
        RX = 1'b0;
        repeat (BIT) @(negedge CLK);
        for (int i = 0; i < 8; i++) begin
            RX = b[i];
            repeat (BIT) @(negedge CLK);
        end
        if (use_par) begin
            RX = pbit;
            repeat (BIT) @(negedge CLK);
        end
        RX = stopb;
        repeat (BIT) @(negedge CLK);
        RX = 1'b1;
        repeat (4) @(negedge CLK);
    endtask

    task automatic test_reset();
        logic [31:0] v;
        reset = 1'b1; RX = 1'b1; A = '0; WD = '0; WE = 1'b0; RE = 1'b0;
        repeat (3) @(negedge CLK);
        n_checks++; if (TX !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b want 1", TX); end
        n_checks++; if (RD !== 32'd0) begin n_fail++; $display("FAIL reset_rd: got %h want 0", RD); end
        n_checks++; if ({irq, imem_WE, cpu_stall, prog_mode} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_ctl: got %b want 0000", {irq, imem_WE, cpu_stall, prog_mode}); end
        n_checks++; if ({imem_A, imem_WD} !== 64'd0) begin
            n_fail++; $display("FAIL reset_imem: got %h want 0", {imem_A, imem_WD}); end
        reset = 1'b0;
        rd(A_STATUS, v);
        n_checks++; if (v !== 32'h2) begin n_fail++; $display("FAIL reset_status: got %h want 2", v); end
        rd(A_BAUD, v);
        n_checks++; if (v !== 32'd5208) begin n_fail++; $display("FAIL reset_baud: got %0d want 5208", v); end
        rd(A_CTRL, v);
        n_checks++; if (v !== 32'd0) begin n_fail++; $display("FAIL reset_ctrl: got %h want 0", v); end
        wr(A_BAUD, 32'd0);
        rd(A_BAUD, v);
        n_checks++; if (v !== 32'd1) begin n_fail++; $display("FAIL baud_zero: got %0d want 1", v); end
    endtask

    task automatic test_reset_mid_tx();
        logic [31:0] v;
        wr(A_BAUD, BIT);
        wr(A_DATA, 32'h55);
        repeat (10) @(negedge CLK);
        n_checks++; if (TX !== 1'b0) begin n_fail++; $display("FAIL midtx_start: got %b want 0", TX); end
        reset = 1'b1;
        #1;
        n_checks++; if (TX !== 1'b1) begin n_fail++; $display("FAIL midtx_reset_tx: got %b want 1", TX); end
        @(negedge CLK);
        reset = 1'b0;
        rd(A_STATUS, v);
        n_checks++; if (v !== 32'h2) begin n_fail++; $display("FAIL midtx_status: got %h want 2", v); end
        rd(A_BAUD, v);
        n_checks++; if (v !== 32'd5208) begin n_fail++; $display("FAIL midtx_baud: got %0d want 5208", v); end
    endtask

    task automatic test_tx_frames();
        logic [31:0] v;
        logic [7:0]  data;
        logic        exp;
        int          k, waited;
        wr(A_BAUD, BIT);
        wr(A_DATA, 32'h55);
        waited = 0;
        while (TX !== 1'b0 && waited < 50) begin
            @(negedge CLK);
            waited++;
        end
        n_checks++; if (TX !== 1'b0) begin n_fail++; $display("FAIL tx_start_timeout: got %b want 0", TX); end
        for (int off = 0; off < 20 * BIT; off++) begin
            if (off == 0) begin A = A_DATA; WD = 32'hA3; WE = 1'b1; end
            if (off == 1) WE = 1'b0;
            data = (off < 10 * BIT) ? 8'h55 : 8'hA3;
            k    = (off / BIT) % 10;
            exp  = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : data[k-1];
            if ((off % BIT) == 1 || (off % BIT) == BIT - 2) begin
                n_checks++;
                if (TX !== exp) begin
                    n_fail++; $display("FAIL tx_bit off=%0d: got %b want %b", off, TX, exp);
                end
            end
            @(negedge CLK);
        end
        n_checks++; if (TX !== 1'b1) begin n_fail++; $display("FAIL tx_idle: got %b want 1", TX); end
        rd(A_STATUS, v);
        n_checks++; if (v !== 32'h2) begin n_fail++; $display("FAIL tx_empty_status: got %h want 2", v); end
    endtask

    task automatic test_parity();
        logic [31:0] v;
        wr(A_CTRL, 32'h04);
        send_byte(8'h5A, 1'b1, 1'b1, 1'b1);
        rd(A_STATUS, v);
        n_checks++; if (v !== 32'h0A) begin n_fail++; $display("FAIL par_err_set: got %h want 0a", v); end
        rd(A_STATUS, v);
        n_checks++; if (v !== 32'h02) begin n_fail++; $display("FAIL par_err_clr: got %h want 02", v); end
        send_byte(8'h5A, 1'b1, 1'b0, 1'b1);
        rd(A_STATUS, v);
        n_checks++; if (v !== 32'h03) begin n_fail++; $display("FAIL par_ok_status: got %h want 03", v); end
        rd(A_DATA, v);
        n_checks++; if (v !== 32'h5A) begin n_fail++; $display("FAIL par_ok_data: got %h want 5a", v); end
        wr(A_CTRL, 32'h0);
    endtask

    task automatic test_overflow();
        logic [31:0] v;
        for (int i = 1; i <= 9; i++) send_byte(8'(i), 1'b0, 1'b0, 1'b1);
        rd(A_STATUS, v);
        n_checks++; if (v !== 32'h23) begin n_fail++; $display("FAIL ovf_status: got %h want 23", v); end
        for (int i = 1; i <= 8; i++) begin
            rd(A_DATA, v);
            n_checks++;
            if (v !== 32'(i)) begin n_fail++; $display("FAIL ovf_read%0d: got %h want %h", i, v, i); end
        end
        rd(A_STATUS, v);
        n_checks++; if (v !== 32'h02) begin n_fail++; $display("FAIL ovf_drained: got %h want 02", v); end
        rd(A_DATA, v);
        n_checks++; if (v !== 32'h0) begin n_fail++; $display("FAIL empty_read: got %h want 0", v); end
    endtask

    task automatic test_prog();
        logic [31:0] v;
        logic [7:0]  bytes [8];
        bytes = '{8'h13, 8'h00, 8'h50, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        we_cnt = 0;
        wr(A_CTRL, 32'h02);
        n_checks++; if ({prog_mode, cpu_stall} !== 2'b11) begin
            n_fail++; $display("FAIL prog_on: got %b want 11", {prog_mode, cpu_stall}); end
        for (int i = 0; i < 8; i++) send_byte(bytes[i], 1'b0, 1'b0, 1'b1);
        n_checks++; if (we_cnt != 2) begin n_fail++; $display("FAIL prog_pulses: got %0d want 2", we_cnt); end
        n_checks++; if (cap_a[0] !== 32'd0 || cap_wd[0] !== 32'h0050_0013) begin
            n_fail++; $display("FAIL prog_word0: got A=%h WD=%h want A=0 WD=00500013", cap_a[0], cap_wd[0]); end
        n_checks++; if (cap_a[1] !== 32'd4 || cap_wd[1] !== 32'hDEAD_BEEF) begin
            n_fail++; $display("FAIL prog_word1: got A=%h WD=%h want A=4 WD=deadbeef", cap_a[1], cap_wd[1]); end
        rd(A_STATUS, v);
        n_checks++; if (v !== 32'h02) begin n_fail++; $display("FAIL prog_bypass: got %h want 02", v); end
        wr(A_CTRL, 32'h0);
        n_checks++; if (prog_mode !== 1'b0) begin n_fail++; $display("FAIL prog_off: got %b want 0", prog_mode); end
    endtask

    task automatic test_glitch_frame();
        logic [31:0] v;
        @(negedge CLK);
        RX = 1'b0;
        repeat (BIT / 4) @(negedge CLK);
        RX = 1'b1;
        repeat (40) @(negedge CLK);
        rd(A_STATUS, v);
        n_checks++; if (v !== 32'h02) begin n_fail++; $display("FAIL glitch_status: got %h want 02", v); end
        send_byte(8'h33, 1'b0, 1'b0, 1'b0);
        rd(A_STATUS, v);
        n_checks++; if (v !== 32'h12) begin n_fail++; $display("FAIL frame_err_set: got %h want 12", v); end
        rd(A_STATUS, v);
        n_checks++; if (v !== 32'h02) begin n_fail++; $display("FAIL frame_err_clr: got %h want 02", v); end
        rd(A_DATA, v);
        n_checks++; if (v !== 32'h0) begin n_fail++; $display("FAIL frame_discard: got %h want 0", v); end
    endtask

    task automatic test_irq();
        logic [31:0] v;
        wr(A_CTRL, 32'h40);
        repeat (3) @(negedge CLK);
        n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_tx: got %b want 1", irq); end
        wr(A_CTRL, 32'h20);
        repeat (3) @(negedge CLK);
        n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_rx_idle: got %b want 0", irq); end
        send_byte(8'h77, 1'b0, 1'b0, 1'b1);
        n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_rx: got %b want 1", irq); end
        rd(A_DATA, v);
        n_checks++; if (v !== 32'h77) begin n_fail++; $display("FAIL irq_data: got %h want 77", v); end
        repeat (3) @(negedge CLK);
        n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_clear: got %b want 0", irq); end
        wr(A_CTRL, 32'h0);
    endtask

    initial begin
        test_reset();
        test_reset_mid_tx();
        test_tx_frames();
        test_parity();
        test_overflow();
        test_prog();
        test_glitch_frame();
        test_irq();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
